cv32e40p_if_pipe_ctrl: RTL

CV32E40P_IF_PIPE_CTRL -- requirements
Module: cv32e40p_if_pipe_ctrl

---
 rtl/cv32e40p_pkg.sv | 26 ++
 rtl/cv32e40p_if_outstanding_cnt.sv | 42 ++++
 rtl/cv32e40p_if_pipe_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the IF-stage pipeline controller.
// Holds the controller state encoding, the default outstanding-fetch limit
// and the counter width used by the controller and its outstanding counter.
package cv32e40p_pkg;

   // Controller states of the IF pipeline control FSM
   typedef enum logic [2:0] {
      IF_IDLE      = 3'd0,
      IF_RUN       = 3'd1,
      IF_DRAIN     = 3'd2,
      IF_HALT_WAIT = 3'd3,
      IF_HALTED    = 3'd4
   } if_ctrl_state_e;

   // Default limit on granted fetches still awaiting a response
   localparam int unsigned IF_MAX_OUTSTANDING_DEFAULT = 2;

   // Counter width: holds 0..3, which covers the whole legal limit range
   localparam int unsigned IF_CNT_W = 2;

   // A state is "busy" when fetch is neither idle nor fully halted
   function automatic logic if_state_busy(input if_ctrl_state_e s);
      return (s != IF_IDLE) && (s != IF_HALTED);
   endfunction

endpackage

// File: rtl/cv32e40p_if_outstanding_cnt.sv
// Outstanding-fetch counter: tracks granted fetches awaiting a response.
// Ports: clk, rst_n (async active-low), inc (grant), dec (response),
//        count (registered value), next_count (value after this cycle).
module cv32e40p_if_outstanding_cnt
   import cv32e40p_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = IF_MAX_OUTSTANDING_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                inc,
   input  logic                dec,
   output logic [IF_CNT_W-1:0] count,
   output logic [IF_CNT_W-1:0] next_count
);

   localparam logic [IF_CNT_W-1:0] MAX_CNT = IF_CNT_W'(MAX_OUTSTANDING);

   // A response with nothing outstanding is spurious and must not wrap the count
   logic dec_eff;
   assign dec_eff = dec & (count != '0);

   always_comb begin
      next_count = count;
      if (inc && !dec_eff) begin
         if (count != MAX_CNT) begin
            next_count = count + IF_CNT_W'(1);
         end
      end else if (!inc && dec_eff) begin
         next_count = count - IF_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= next_count;
      end
   end

endmodule

// File: rtl/cv32e40p_if_pipe_ctrl.sv
// IF-stage pipeline controller: gates fetch requests, drains stale responses
// after a PC redirect and handles halt requests with a clean halted state.
// Ports: fetch/redirect/halt controls in, fetch grant/response in; fetch
//        request, IF-ID freeze/clear, discard, halt ack, busy, count out.
module cv32e40p_if_pipe_ctrl
   import cv32e40p_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = IF_MAX_OUTSTANDING_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fetch_enable_i,
   input  logic                pc_set_i,
   input  logic                halt_req_i,
   input  logic                id_ready_i,
   input  logic                if_valid_i,
   input  logic                instr_gnt_i,
   input  logic                instr_rvalid_i,
   output logic                fetch_req_o,
   output logic                halt_if_o,
   output logic                clear_instr_valid_o,
   output logic                discard_rvalid_o,
   output logic                halt_ack_o,
   output logic                busy_o,
   output logic [IF_CNT_W-1:0] outstanding_o
);

   localparam logic [IF_CNT_W-1:0] MAX_CNT = IF_CNT_W'(MAX_OUTSTANDING);

   if_ctrl_state_e      state;
   logic [IF_CNT_W-1:0] count;
   logic [IF_CNT_W-1:0] next_count;
   logic                fetch_inc;

   // Request depends only on registered state/count and this cycle's response,
   // never on the grant, so the grant-to-request loop stays open.
   assign fetch_req_o = (state == IF_RUN) & ~pc_set_i & ~halt_req_i &
                        ((count < MAX_CNT) | instr_rvalid_i);

   assign fetch_inc = fetch_req_o & instr_gnt_i;

   cv32e40p_if_outstanding_cnt #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_outstanding_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (fetch_inc),
      .dec        (instr_rvalid_i),
      .count      (count),
      .next_count (next_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IF_IDLE;
      end else begin
         unique case (state)
            IF_IDLE: begin
               if (fetch_enable_i) state <= IF_RUN;
            end
            IF_RUN: begin
               // A redirect takes priority over a halt; with nothing in flight
               // there is nothing stale to drop, so fetch continues directly.
               if (pc_set_i) begin
                  if (next_count != '0) state <= IF_DRAIN;
               end else if (halt_req_i) begin
                  state <= IF_HALT_WAIT;
               end
            end
            IF_DRAIN: begin
               // Another redirect restarts the drain; exit is re-evaluated next cycle
               if (!pc_set_i && (next_count == '0)) begin
                  state <= halt_req_i ? IF_HALTED : IF_RUN;
               end
            end
            IF_HALT_WAIT: begin
               // Responses arriving here are still valid; a redirect makes them stale
               if (pc_set_i) begin
                  state <= IF_DRAIN;
               end else if (next_count == '0) begin
                  state <= IF_HALTED;
               end
            end
            IF_HALTED: begin
               if (!halt_req_i) state <= IF_RUN;
            end
            default: state <= IF_IDLE;
         endcase
      end
   end

   assign halt_if_o           = (state != IF_RUN);
   assign clear_instr_valid_o = pc_set_i | (id_ready_i & ~if_valid_i) | (state == IF_HALTED);
   assign discard_rvalid_o    = (state == IF_DRAIN) & instr_rvalid_i;
   assign halt_ack_o          = (state == IF_HALTED);
   assign busy_o              = if_state_busy(state);
   assign outstanding_o       = count;

`ifndef SYNTHESIS
   // A response with no fetch in flight indicates a bus protocol error upstream
   a_no_spurious_rvalid : assert property (
      @(posedge clk) disable iff (!rst_n) instr_rvalid_i |-> (count != '0)
   );
`endif

endmodule
